// File: rtl/bin_incrementer.sv
// bin_incrementer
//   Registered WIDTH-bit binary incrementer: {cout,S} = A + 1, built from an
//   explicit ripple chain of half-adder stages, registered once per accepted
//   input (one-cycle latency, one result per cycle when in_valid is held high).
//   WIDTH is intended for the range 1..32.
//
//   Optional feature, selected with the macro BIN_INC_SATURATE_EN:
//     defined   - A = all-ones gives S = all-ones and cout = 1 (cout means "saturated").
//     undefined - S wraps to zero and cout is the true carry-out (default build).

// One half-adder stage: sum and carry of two single bits.
module bin_inc_half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;

endmodule

module bin_incrementer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             out_valid
);

  // Combinational ripple result.
  logic [WIDTH-1:0] w_s;
  logic             w_carry;
  logic [WIDTH-1:0] w_sum;

  // Registered outputs.
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_out_valid;

  // Half-adder chain. Each stage owns its carry signals, so the chain is a
  // plain sequence of single-bit nets rather than one vector that depends on
  // itself. Stage 0 adds the constant 1 that makes this an incrementer.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stage
      logic w_ci;
      logic w_co;

      if (gi == 0) begin : g_first
        assign w_ci = 1'b1;
      end else begin : g_rest
        assign w_ci = g_stage[gi-1].w_co;
      end

      bin_inc_half_adder u_ha (
        .i_a (A[gi]),
        .i_b (w_ci),
        .o_s (w_s[gi]),
        .o_c (w_co)
      );
    end
  endgenerate

  assign w_carry = g_stage[WIDTH-1].w_co;

`ifdef BIN_INC_SATURATE_EN
  // The carry out of the top stage only occurs for A = all-ones; clamp there.
  assign w_sum = w_carry ? {WIDTH{1'b1}} : w_s;
`else
  assign w_sum = w_s;
`endif

  // Capture the result on accepted inputs; hold sum/carry otherwise, and
  // clear everything (including any in-flight result) on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_s    <= w_sum;
        r_cout <= w_carry;
      end
    end
  end

  assign S         = r_s;
  assign cout      = r_cout;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_bin_incrementer.sv
// Testbench for bin_incrementer: WIDTH=4 instance checked through a scoreboard
// of expected {cout,S} values, plus a WIDTH=8 instance for a spot check.
// Honors BIN_INC_SATURATE_EN when computing expected results.
module tb_bin_incrementer;

  localparam int W = 4;

  typedef struct packed {
    logic         cout;
    logic [W-1:0] s;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] s;
  logic         cout;
  logic         out_valid;

  logic         in_valid8 = 1'b0;
  logic [7:0]   a8 = '0;
  logic [7:0]   s8;
  logic         cout8;
  logic         out_valid8;

  int   n_compared   = 0;
  int   n_mismatched = 0;
  res_t sb_q[$];
  res_t last_res = '0;

  always #5 clk = ~clk;

  bin_incrementer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a),
    .S         (s),
    .cout      (cout),
    .out_valid (out_valid)
  );

  bin_incrementer #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .A         (a8),
    .S         (s8),
    .cout      (cout8),
    .out_valid (out_valid8)
  );

  // Reference: plain addition, with clamping in the saturating build.
  function automatic res_t model(input logic [W-1:0] av);
    logic [W:0] full;
    full = {1'b0, av} + (W+1)'(1);
`ifdef BIN_INC_SATURATE_EN
    if (full[W]) full = {1'b1, {W{1'b1}}};
`endif
    return res_t'(full);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: drive inputs, push the expectation, then check
  // one edge later. With in_valid=0 the outputs must hold the last result.
  task automatic step(input logic v, input logic [W-1:0] av);
    res_t r;
    in_valid = v;
    a        = av;
    if (v) sb_q.push_back(model(av));
    @(posedge clk);
    #1;
    check($sformatf("out_valid A=%0h v=%0d", av, v), 32'(out_valid), 32'(v));
    if (v && sb_q.size() > 0) begin
      r        = sb_q.pop_front();
      last_res = r;
    end
    check($sformatf("%s A=%0h", v ? "result" : "hold", av), 32'({cout, s}), 32'(last_res));
  endtask

  initial begin
    logic [8:0] exp8;

    // 1. Reset held with a valid input present: outputs stay cleared.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 4'b1010;
    repeat (2) @(posedge clk);
    #1;
    check("rst S", 32'(s), 32'd0);
    check("rst cout", 32'(cout), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    check("release no change", 32'({out_valid, cout, s}), 32'd0);
    step(1'b1, 4'b1010);

    // 2-4. Basic increments, carry ripple and the all-ones boundary.
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0001);
    step(1'b1, 4'b0111);
    step(1'b1, 4'b1010);
    step(1'b1, 4'b1111);

    // 5. in_valid low with A changing: outputs hold.
    step(1'b0, 4'b0011);
    step(1'b0, 4'b0101);

    // Exhaustive, back-to-back.
    for (int i = 0; i < 16; i++) step(1'b1, W'(i));

    // 6. Asynchronous reset between edges while an input is in flight.
    step(1'b1, 4'b0010);
    in_valid = 1'b1;
    a        = 4'b0100;
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst clears", 32'({out_valid, cout, s}), 32'd0);
    last_res = '0;
    @(posedge clk);
    #1;
    check("rst held", 32'({out_valid, cout, s}), 32'd0);
    #2;
    rst_n = 1'b1;
    #1;
    step(1'b0, 4'b1001);
    step(1'b1, 4'b1110);
    step(1'b1, 4'b1111);
    in_valid = 1'b0;

    // WIDTH=8 spot checks.
    in_valid8 = 1'b1;
    a8        = 8'hFF;
    exp8      = 9'h100;
`ifdef BIN_INC_SATURATE_EN
    exp8 = 9'h1FF;
`endif
    @(posedge clk);
    #1;
    check("w8 out_valid", 32'(out_valid8), 32'd1);
    check("w8 A=FF", 32'({cout8, s8}), 32'(exp8));
    a8 = 8'h7F;
    @(posedge clk);
    #1;
    check("w8 A=7F", 32'({cout8, s8}), 32'h080);
    in_valid8 = 1'b0;
    a8        = 8'h12;
    @(posedge clk);
    #1;
    check("w8 idle out_valid", 32'(out_valid8), 32'd0);
    check("w8 hold", 32'({cout8, s8}), 32'h080);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
